// File: rtl/tmnt_io_pkg.sv
// Shared definitions for the cabinet I/O front end: coin-counter FSM states and
// the mapping of coin slots onto the two coin-counter solenoids.
package tmnt_io_pkg;

   typedef enum logic [1:0] {
      CC_IDLE = 2'd0,
      CC_ON   = 2'd1,
      CC_GAP  = 2'd2
   } cc_state_t;

   localparam int N_SLOT = 4;
   localparam int N_SERV = 4;
   localparam int N_CTR  = 2;

   // Bit i holds the counter index driven by coin slot i (slots 0,2 -> 0; 1,3 -> 1).
   localparam logic [N_SLOT-1:0] SLOT_CTR_MAP = 4'b1010;

   function automatic logic slot_on_ctr(input int slot, input logic ctr);
      return SLOT_CTR_MAP[slot] == ctr;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// One cabinet input bit: two-flop synchroniser followed by a stable-time debouncer.
// The pin is active-low; the level output is active-high.
module io_debounce #(
   parameter int DEB_CYC = 1024
) (
   input  logic clk_main,
   input  logic reset,
   input  logic pin_n,
   output logic level
);

   localparam int               TMR_W    = $clog2(DEB_CYC) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEB_CYC - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             stable_n;
   logic [TMR_W-1:0] tmr;

   always_ff @(posedge clk_main) begin
      if (reset) begin
         sync_p0  <= 1'b1;
         sync_p1  <= 1'b1;
         stable_n <= 1'b1;
         tmr      <= '0;
      end else begin
         sync_p0 <= pin_n;
         sync_p1 <= sync_p0;
         // Any sample that agrees with the stable value restarts the qualification window.
         if (sync_p1 == stable_n) begin
            tmr <= '0;
         end else if (tmr == TMR_LAST) begin
            stable_n <= sync_p1;
            tmr      <= '0;
         end else begin
            tmr <= tmr + 1'b1;
         end
      end
   end

   assign level = ~stable_n;

endmodule

// File: rtl/coin_ctrl.sv
// Coin-mech front end: debounces coin/service switches, raises coin-insert events and
// schedules the two coin-counter solenoids with a per-counter pending-coin queue.
module coin_ctrl
   import tmnt_io_pkg::*;
#(
   parameter int DEB_CYC   = 1024,
   parameter int PULSE_CYC = 4800000,
   parameter int GAP_CYC   = 4800000,
   parameter int PEND_W    = 3
) (
   input  logic       clk_main,
   input  logic       reset,
   input  logic [3:0] P_coin,
   input  logic [3:0] service,
   input  logic [3:0] coin_lockout,
   input  logic       ovf_clr,
   output logic [3:0] coin_level,
   output logic [3:0] serv_level,
   output logic [3:0] coin_evt,
   output logic [1:0] coin_counter,
   output logic [1:0] ovf
);

   localparam int PULSE_W = $clog2(PULSE_CYC) + 1;
   localparam int GAP_W   = $clog2(GAP_CYC) + 1;
   localparam int TMR_W   = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;

   localparam logic [TMR_W-1:0]  PULSE_LAST = TMR_W'(PULSE_CYC - 1);
   localparam logic [TMR_W-1:0]  GAP_LAST   = TMR_W'(GAP_CYC - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = '1;

   // Net queue update with saturation; the top bit flags that coins were lost.
   function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cur,
                                                 input logic [1:0]        add,
                                                 input logic              sub);
      logic [PEND_W+1:0] sum;
      sum = (PEND_W+2)'(cur) + (PEND_W+2)'(add) - (PEND_W+2)'(sub);
      if (sum > (PEND_W+2)'(PEND_MAX)) begin
         return {1'b1, PEND_MAX};
      end
      return {1'b0, sum[PEND_W-1:0]};
   endfunction

   logic [7:0] raw_n;
   logic [7:0] lvl_p0;
   logic [3:0] coin_level_p1;

   assign raw_n = {service, P_coin};

   for (genvar i = 0; i < N_SLOT + N_SERV; i++) begin : gen_deb
      io_debounce #(
         .DEB_CYC (DEB_CYC)
      ) u_deb (
         .clk_main (clk_main),
         .reset    (reset),
         .pin_n    (raw_n[i]),
         .level    (lvl_p0[i])
      );
   end

   assign coin_level = lvl_p0[3:0];
   assign serv_level = lvl_p0[7:4];

   // Event stage: rising edge of the debounced coin level, gated by lockout at that moment.
   always_ff @(posedge clk_main) begin
      if (reset) begin
         coin_level_p1 <= '0;
         coin_evt      <= '0;
      end else begin
         coin_level_p1 <= coin_level;
         coin_evt      <= coin_level & ~coin_level_p1 & ~coin_lockout;
      end
   end

   for (genvar c = 0; c < N_CTR; c++) begin : gen_ctr
      localparam logic CTR = 1'(c);

      cc_state_t         state;
      cc_state_t         state_nx;
      logic [TMR_W-1:0]  tmr;
      logic [PEND_W-1:0] pend;
      logic [PEND_W:0]   pend_upd;
      logic [1:0]        inc;
      logic              take;
      logic              on_q;
      logic              ovf_q;

      always_comb begin
         inc = '0;
         for (int s = 0; s < N_SLOT; s++) begin
            if (slot_on_ctr(s, CTR) && coin_evt[s]) begin
               inc = inc + 2'd1;
            end
         end
      end

      always_comb begin
         state_nx = state;
         take     = 1'b0;
         case (state)
            CC_IDLE: begin
               if (pend != '0) begin
                  state_nx = CC_ON;
                  take     = 1'b1;
               end
            end
            CC_ON: begin
               if (tmr == PULSE_LAST) begin
                  state_nx = CC_GAP;
               end
            end
            CC_GAP: begin
               if (tmr == GAP_LAST) begin
                  if (pend != '0) begin
                     state_nx = CC_ON;
                     take     = 1'b1;
                  end else begin
                     state_nx = CC_IDLE;
                  end
               end
            end
            default: state_nx = CC_IDLE;
         endcase
      end

      assign pend_upd = pend_next(pend, inc, take);

      always_ff @(posedge clk_main) begin
         if (reset) begin
            state <= CC_IDLE;
            tmr   <= '0;
            pend  <= '0;
            on_q  <= 1'b0;
            ovf_q <= 1'b0;
         end else begin
            state <= state_nx;
            // The timer measures time spent in ON/GAP; any state change starts it afresh.
            if ((state_nx != state) || (state == CC_IDLE)) begin
               tmr <= '0;
            end else begin
               tmr <= tmr + 1'b1;
            end
            pend <= pend_upd[PEND_W-1:0];
            on_q <= (state_nx == CC_ON);
            if (pend_upd[PEND_W]) begin
               ovf_q <= 1'b1;
            end else if (ovf_clr) begin
               ovf_q <= 1'b0;
            end
         end
      end

      assign coin_counter[c] = on_q;
      assign ovf[c]          = ovf_q;
   end

endmodule

// File: tb/tb_coin_ctrl.sv
// Directed bench for coin_ctrl with short debounce/pulse timing; expected values are
// worked out by hand against edge counts from each stimulus change.
module tb_coin_ctrl;

   logic       clk_main = 1'b0;
   logic       reset;
   logic [3:0] P_coin;
   logic [3:0] service;
   logic [3:0] coin_lockout;
   logic       ovf_clr;
   logic [3:0] coin_level;
   logic [3:0] serv_level;
   logic [3:0] coin_evt;
   logic [1:0] coin_counter;
   logic [1:0] ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_main = ~clk_main;

   coin_ctrl #(
      .DEB_CYC   (4),
      .PULSE_CYC (8),
      .GAP_CYC   (6),
      .PEND_W    (3)
   ) dut (
      .clk_main     (clk_main),
      .reset        (reset),
      .P_coin       (P_coin),
      .service      (service),
      .coin_lockout (coin_lockout),
      .ovf_clr      (ovf_clr),
      .coin_level   (coin_level),
      .serv_level   (serv_level),
      .coin_evt     (coin_evt),
      .coin_counter (coin_counter),
      .ovf          (ovf)
   );

   task automatic tick();
      @(posedge clk_main);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      logic prev;
      logic [3:0] exp_lvl;
      logic [3:0] exp_evt;
      logic [1:0] exp_ctr;

      reset        = 1'b1;
      P_coin       = 4'b0000;
      service      = 4'hF;
      coin_lockout = 4'h0;
      ovf_clr      = 1'b0;

      // 1. reset with all coin pins pressed, then debounce latency after release
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("rst_lvl_%0d", i), {serv_level, coin_level}, 8'h00);
         check($sformatf("rst_out_%0d", i), {coin_evt, coin_counter, ovf}, 8'h00);
      end
      reset = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         tick();
         exp_lvl = (n >= 6) ? 4'hF : 4'h0;
         check($sformatf("t1_lvl_%0d", n), {4'h0, coin_level}, {4'h0, exp_lvl});
      end
      reset  = 1'b1;
      P_coin = 4'hF;
      tick();
      tick();
      check("t1_rst2", {coin_level, coin_evt}, 8'h00);
      check("t1_rst2_ctr", {4'h0, coin_counter, ovf}, 8'h00);
      reset = 1'b0;
      repeat (10) tick();

      // 2. three-cycle glitch on slot 0
      P_coin = 4'b1110;
      for (int n = 1; n <= 15; n++) begin
         tick();
         if (n == 3) P_coin = 4'hF;
         check($sformatf("t2_lvl_evt_%0d", n), {coin_level, coin_evt}, 8'h00);
         check($sformatf("t2_ctr_%0d", n), {6'h0, coin_counter}, 8'h00);
      end

      // 3. single coin on slot 1 held for 20 cycles
      for (int k = 0; k < 40; k++) begin
         int n;
         P_coin = (k < 20) ? 4'b1101 : 4'hF;
         tick();
         n = k + 1;
         exp_lvl = (n >= 6 && n < 26) ? 4'b0010 : 4'b0000;
         exp_evt = (n == 7) ? 4'b0010 : 4'b0000;
         exp_ctr = (n >= 9 && n <= 16) ? 2'b10 : 2'b00;
         check($sformatf("t3_lvl_evt_%0d", n), {coin_level, coin_evt}, {exp_lvl, exp_evt});
         check($sformatf("t3_ctr_%0d", n), {6'h0, coin_counter}, {6'h0, exp_ctr});
      end

      // 4. slots 0 and 2 together: two queued pulses on counter 0
      for (int k = 0; k < 45; k++) begin
         int n;
         P_coin = (k < 10) ? 4'b1010 : 4'hF;
         tick();
         n = k + 1;
         exp_lvl = (n >= 6 && n < 16) ? 4'b0101 : 4'b0000;
         exp_evt = (n == 7) ? 4'b0101 : 4'b0000;
         exp_ctr = ((n >= 9 && n <= 16) || (n >= 23 && n <= 30)) ? 2'b01 : 2'b00;
         check($sformatf("t4_lvl_evt_%0d", n), {coin_level, coin_evt}, {exp_lvl, exp_evt});
         check($sformatf("t4_ctr_%0d", n), {6'h0, coin_counter}, {6'h0, exp_ctr});
      end

      // 5. six double inserts on slots 1 and 3 every 8 cycles: queue saturates
      pulses = 0;
      prev   = 1'b0;
      for (int k = 0; k < 160; k++) begin
         int n;
         P_coin = (k < 48 && (k % 8) < 4) ? 4'b0101 : 4'hF;
         tick();
         n = k + 1;
         if (coin_counter[1] && !prev) pulses++;
         prev = coin_counter[1];
         check($sformatf("t5_ctr0_%0d", n), {7'h0, coin_counter[0]}, 8'h00);
         if (n == 7)   check("t5_evt_7", {4'h0, coin_evt}, 8'h0A);
         if (n == 9)   check("t5_ctr_9", {6'h0, coin_counter}, 8'h02);
         if (n == 47)  check("t5_ovf_47", {6'h0, ovf}, 8'h00);
         if (n == 48)  check("t5_ovf_48", {6'h0, ovf}, 8'h02);
         if (n == 142) check("t5_ctr_142", {6'h0, coin_counter}, 8'h02);
         if (n == 143) check("t5_ctr_143", {6'h0, coin_counter}, 8'h00);
      end
      check("t5_pulses", 8'(pulses), 8'd10);
      check("t5_ovf_end", {6'h0, ovf}, 8'h02);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("t5_ovf_clr", {6'h0, ovf}, 8'h00);

      // 6. slot 3 locked out, slot 0 pressed alongside; reset mid-pulse
      coin_lockout = 4'b1000;
      for (int k = 0; k < 12; k++) begin
         int n;
         P_coin = 4'b0110;
         tick();
         n = k + 1;
         exp_lvl = (n >= 6) ? 4'b1001 : 4'b0000;
         exp_evt = (n == 7) ? 4'b0001 : 4'b0000;
         exp_ctr = (n >= 9) ? 2'b01 : 2'b00;
         check($sformatf("t6_lvl_evt_%0d", n), {coin_level, coin_evt}, {exp_lvl, exp_evt});
         check($sformatf("t6_ctr_%0d", n), {6'h0, coin_counter}, {6'h0, exp_ctr});
      end
      reset  = 1'b1;
      P_coin = 4'hF;
      tick();
      check("t6_rst_ctr", {4'h0, coin_counter, ovf}, 8'h00);
      check("t6_rst_lvl", {coin_level, coin_evt}, 8'h00);
      tick();
      reset        = 1'b0;
      coin_lockout = 4'h0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         check($sformatf("t6_post_%0d", n), {2'b00, coin_counter, coin_evt}, 8'h00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
